// File: rtl/evnt_timer.sv
// evnt_timer -- periodic event tick, CPU clock-enable divider and debounced
// timer on/off switch that raises the timer interrupt request.
//
// Parameters
//   CLKREF   clk_p frequency in Hz
//   EVT_HZ   event tick rate in Hz (tick period = CLKREF/EVT_HZ cycles)
//   SLOW_DIV CPU clock-enable divide ratio in slow mode
//   DEB_LEN  number of tick-rate button samples that must agree
//   EVT_MODE 0 = vm_evnt is a one-cycle pulse, 1 = vm_evnt latched until acked
//
// Ports
//   clk_p          in   single clock, rising edge
//   dclo           in   synchronous active-high reset
//   cpuslow        in   1 = divided CPU enable, 0 = enable every cycle
//   cpu_clk_enable out  CPU clock-enable strobe (registered)
//   timer_button   in   raw, undebounced timer on/off button
//   timer_status   out  timer enabled flag
//   evnt_ack       in   CPU acknowledge of a latched event (EVT_MODE=1 only)
//   vm_evnt        out  timer interrupt request
//   evt_tick       out  raw periodic tick, one cycle wide (registered)
//   evt_miss       out  sticky overrun flag (EVT_MODE=1 only, else 0)

module evnt_timer #(
    parameter int CLKREF   = 100000000,
    parameter int EVT_HZ   = 50,
    parameter int SLOW_DIV = 22,
    parameter int DEB_LEN  = 2,
    parameter int EVT_MODE = 0
) (
    input  logic clk_p,
    input  logic dclo,
    input  logic cpuslow,
    output logic cpu_clk_enable,
    input  logic timer_button,
    output logic timer_status,
    input  logic evnt_ack,
    output logic vm_evnt,
    output logic evt_tick,
    output logic evt_miss
);

    // Guarded so an illegal EVT_HZ reaches the checks below instead of a
    // divide-by-zero during parameter evaluation.
    localparam int TLIM = (EVT_HZ > 0) ? (CLKREF / EVT_HZ - 1) : 1;
    localparam int TW   = (TLIM > 0) ? $clog2(TLIM + 1) : 1;
    localparam int SW   = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;

    localparam logic [TW-1:0] TLIM_W    = TW'(TLIM);
    localparam logic [SW-1:0] SLOW_LAST = SW'(SLOW_DIV - 1);

    generate
        if (EVT_HZ == 0) begin : g_bad_hz
            $error("evnt_timer: EVT_HZ must be non-zero");
        end
        if (EVT_HZ > 0 && (CLKREF / EVT_HZ) < 2) begin : g_bad_ratio
            $error("evnt_timer: CLKREF/EVT_HZ must be at least 2");
        end
        if (SLOW_DIV < 2) begin : g_bad_div
            $error("evnt_timer: SLOW_DIV must be at least 2");
        end
        if (DEB_LEN < 2) begin : g_bad_deb
            $error("evnt_timer: DEB_LEN must be at least 2");
        end
        if (EVT_MODE < 0 || EVT_MODE > 1) begin : g_bad_mode
            $error("evnt_timer: EVT_MODE must be 0 or 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SW-1:0]      div_reg,   div_next;
    logic [TW-1:0]      tcnt_reg,  tcnt_next;
    logic               cpu_en_reg;
    logic               evt_tick_reg;
    logic [DEB_LEN-1:0] deb_reg,   deb_next;
    logic               armed_reg, armed_next;
    logic               timer_status_reg, timer_status_next;

    // ------------------------------------------------------------------
    // Free-running counters
    // ------------------------------------------------------------------
    always_comb begin
        div_next  = (div_reg == SLOW_LAST) ? '0 : div_reg + SW'(1);
        tcnt_next = (tcnt_reg == TLIM_W) ? '0 : tcnt_reg + TW'(1);
    end

    // ------------------------------------------------------------------
    // Debounce: shift one button sample per tick. Bit 0 holds the newest.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEB_LEN; gi = gi + 1) begin : g_deb
            if (gi == 0) begin : g_head
                assign deb_next[gi] = evt_tick_reg ? timer_button : deb_reg[gi];
            end else begin : g_body
                assign deb_next[gi] = evt_tick_reg ? deb_reg[gi-1] : deb_reg[gi];
            end
        end
    endgenerate

    // Status is judged on the window including the sample being shifted in
    // this tick, so the toggle lands on the same edge as the final sample.
    // armed stops a held button from toggling again on every later tick.
    always_comb begin
        timer_status_next = timer_status_reg;
        armed_next        = armed_reg;
        if (evt_tick_reg) begin
            if ((&deb_next) && armed_reg) begin
                timer_status_next = ~timer_status_reg;
                armed_next        = 1'b0;
            end else if (~|deb_next) begin
                armed_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_p) begin
        if (dclo) begin
            div_reg          <= '0;
            tcnt_reg         <= '0;
            cpu_en_reg       <= 1'b0;
            evt_tick_reg     <= 1'b0;
            deb_reg          <= '0;
            armed_reg        <= 1'b1;
            timer_status_reg <= 1'b0;
        end else begin
            div_reg          <= div_next;
            tcnt_reg         <= tcnt_next;
            cpu_en_reg       <= cpuslow ? (div_reg == SLOW_LAST) : 1'b1;
            evt_tick_reg     <= (tcnt_reg == TLIM_W);
            deb_reg          <= deb_next;
            armed_reg        <= armed_next;
            timer_status_reg <= timer_status_next;
        end
    end

    assign cpu_clk_enable = cpu_en_reg;
    assign evt_tick       = evt_tick_reg;
    assign timer_status   = timer_status_reg;

    // ------------------------------------------------------------------
    // Interrupt request
    // ------------------------------------------------------------------
    generate
        if (EVT_MODE == 0) begin : g_pulse
            // Acknowledge has no meaning for a self-clearing pulse.
            logic unused_ack;
            assign unused_ack = evnt_ack;
            assign vm_evnt    = evt_tick_reg & timer_status_reg;
            assign evt_miss   = 1'b0;
        end else begin : g_latch
            logic vm_reg;
            logic miss_reg;
            logic set_evt;

            assign set_evt = evt_tick_reg & timer_status_reg;

            // Set beats ack; an unacknowledged request hit by a new set is
            // recorded as an overrun until the next reset.
            always_ff @(posedge clk_p) begin
                if (dclo) begin
                    vm_reg   <= 1'b0;
                    miss_reg <= 1'b0;
                end else begin
                    if (set_evt) begin
                        vm_reg <= 1'b1;
                    end else if (evnt_ack || !timer_status_reg) begin
                        vm_reg <= 1'b0;
                    end
                    if (set_evt && vm_reg && !evnt_ack) begin
                        miss_reg <= 1'b1;
                    end
                end
            end

            assign vm_evnt  = vm_reg;
            assign evt_miss = miss_reg;
        end
    endgenerate

endmodule

// File: tb/tb_evnt_timer.sv
// Randomized bench for evnt_timer. Two instances (pulse mode and latched
// mode) share all inputs; a reference model that tracks the number of
// edges since reset and a window of button samples predicts every output.

module tb_evnt_timer;

    localparam int CLKREF = 1000;
    localparam int EVT_HZ = 50;
    localparam int PERIOD = CLKREF / EVT_HZ;   // tick period in cycles
    localparam int SDIV   = 22;
    localparam int DEB    = 2;
    localparam int NCYC   = 8000;

    logic clk_p = 1'b0;
    logic dclo, cpuslow, timer_button, evnt_ack;
    logic en0, st0, vm0, tk0, ms0;
    logic en1, st1, vm1, tk1, ms1;

    always #5 clk_p = ~clk_p;

    evnt_timer #(
        .CLKREF(CLKREF), .EVT_HZ(EVT_HZ), .SLOW_DIV(SDIV), .DEB_LEN(DEB), .EVT_MODE(0)
    ) u_dut0 (
        .clk_p(clk_p), .dclo(dclo), .cpuslow(cpuslow), .cpu_clk_enable(en0),
        .timer_button(timer_button), .timer_status(st0), .evnt_ack(evnt_ack),
        .vm_evnt(vm0), .evt_tick(tk0), .evt_miss(ms0)
    );

    evnt_timer #(
        .CLKREF(CLKREF), .EVT_HZ(EVT_HZ), .SLOW_DIV(SDIV), .DEB_LEN(DEB), .EVT_MODE(1)
    ) u_dut1 (
        .clk_p(clk_p), .dclo(dclo), .cpuslow(cpuslow), .cpu_clk_enable(en1),
        .timer_button(timer_button), .timer_status(st1), .evnt_ack(evnt_ack),
        .vm_evnt(vm1), .evt_tick(tk1), .evt_miss(ms1)
    );

    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic obs, input logic exp, input int cyc);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0b, expected %0b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int k;              // non-reset edges since the last reset edge
    bit m_tick, m_en, m_status, m_armed, m_vm, m_miss;
    bit m_hist[DEB];    // button samples taken at ticks, [0] newest

    task automatic model_edge();
        int ones;
        bit set_c;
        if (dclo) begin
            k = 0;
            m_tick = 0; m_en = 0; m_status = 0; m_armed = 1; m_vm = 0; m_miss = 0;
            for (int i = 0; i < DEB; i++) m_hist[i] = 0;
        end else begin
            // latched request uses the status seen before this edge
            set_c = m_tick && m_status;
            if (set_c) begin
                if (m_vm && !evnt_ack) m_miss = 1;
                m_vm = 1;
            end else if (evnt_ack || !m_status) begin
                m_vm = 0;
            end
            if (m_tick) begin
                for (int i = DEB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
                m_hist[0] = timer_button;
                ones = 0;
                for (int i = 0; i < DEB; i++) ones += int'(m_hist[i]);
                if (ones == DEB && m_armed) begin
                    m_status = !m_status;
                    m_armed  = 0;
                end else if (ones == 0) begin
                    m_armed = 1;
                end
            end
            k++;
            m_tick = (k % PERIOD) == 0;
            m_en   = cpuslow ? ((k % SDIV) == 0) : 1'b1;
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus and checking
    // ------------------------------------------------------------------
    initial begin
        bit btn_level;
        int dclo_hold;
        bit forced_rst;
        n_checks = 0;
        n_fail   = 0;
        btn_level  = 0;
        dclo_hold  = 0;
        forced_rst = 0;
        dclo = 1'b1; cpuslow = 1'b1; timer_button = 1'b0; evnt_ack = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            model_edge();
            @(posedge clk_p);
            @(negedge clk_p);

            check_eq("tick0",   tk0, m_tick, cyc);
            check_eq("tick1",   tk1, m_tick, cyc);
            check_eq("cpu_en0", en0, m_en, cyc);
            check_eq("cpu_en1", en1, m_en, cyc);
            check_eq("status0", st0, m_status, cyc);
            check_eq("status1", st1, m_status, cyc);
            check_eq("vm0",     vm0, m_tick & m_status, cyc);
            check_eq("miss0",   ms0, 1'b0, cyc);
            check_eq("vm1",     vm1, m_vm, cyc);
            check_eq("miss1",   ms1, m_miss, cyc);

            if (m_tick)
                $display("tick cycle %0d: sample=%0b status=%0b vm1=%0b miss1=%0b cpuslow=%0b",
                         cyc, m_hist[0], m_status, m_vm, m_miss, cpuslow);

            // next cycle's inputs
            if (cyc < 2) begin
                dclo = 1'b1;
            end else if (dclo_hold > 0) begin
                dclo = 1'b1;
                dclo_hold--;
            end else if (!forced_rst && m_vm && m_miss && m_status) begin
                dclo = 1'b1;
                forced_rst = 1;
            end else if ($urandom_range(0, 1999) == 0) begin
                dclo = 1'b1;
                dclo_hold = $urandom_range(0, 2);
            end else begin
                dclo = 1'b0;
            end

            if ($urandom_range(0, 299) == 0) cpuslow = ~cpuslow;
            if ($urandom_range(0, 39) == 0) btn_level = 1'($urandom_range(0, 1));
            timer_button = btn_level ^ ($urandom_range(0, 29) == 0);
            evnt_ack = ($urandom_range(0, 39) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/evnt_timer.md
EVNT_TIMER -- requirements
Module: evnt_timer

Interface
REQ-001 Parameter CLKREF, default 100000000, SHALL give the clk_p frequency in Hz.
REQ-002 Parameter EVT_HZ, default 50, SHALL give the event tick rate in Hz.
REQ-003 Parameter SLOW_DIV, default 22, SHALL give the CPU clock-enable divide ratio in slow mode.
REQ-004 Parameter DEB_LEN, default 2, SHALL give the number of button samples in the debounce shift register.
REQ-005 Parameter EVT_MODE, default 0, SHALL select the event mode: 0 = single-cycle pulse, 1 = latched until acknowledged.
REQ-006 clk_p  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 dclo  in  1  SHALL be the reset: synchronous, active-high.
REQ-008 cpuslow  in  1  SHALL select the CPU mode: 1 = slow (divided), 0 = full-rate enable.
REQ-009 cpu_clk_enable  out  1  SHALL be the CPU clock-enable strobe.
REQ-010 timer_button  in  1  SHALL be the raw, undebounced timer on/off button.
REQ-011 timer_status  out  1  SHALL be the timer enabled flag (indicator).
REQ-012 evnt_ack  in  1  SHALL be the CPU acknowledge of a latched event; it is ignored when EVT_MODE=0.
REQ-013 vm_evnt  out  1  SHALL be the timer interrupt request to the CPU.
REQ-014 evt_tick  out  1  SHALL be the raw periodic tick, one cycle wide.
REQ-015 evt_miss  out  1  SHALL be a sticky overrun flag.

Function
REQ-016 Counter widths SHALL be derived with $clog2 from TLIM = CLKREF/EVT_HZ-1 and from SLOW_DIV-1; no truncation is permitted.
REQ-017 Elaboration SHALL fail if EVT_HZ=0, CLKREF/EVT_HZ<2, SLOW_DIV<2, DEB_LEN<2, or EVT_MODE>1.
REQ-018 The slow divider SHALL count 0..SLOW_DIV-1, wrap to 0 and free-run regardless of cpuslow.
REQ-019 cpu_clk_enable SHALL be registered: with cpuslow=1 it is 1 for exactly one cycle following each cycle in which the divider equals SLOW_DIV-1; with cpuslow=0 it is 1 every cycle.
REQ-020 A cpuslow change SHALL take effect on the next edge and SHALL NOT reset the divider.
REQ-021 The tick counter SHALL count 0..TLIM and wrap to 0.
REQ-022 evt_tick SHALL be registered and equal to 1 for one cycle following each cycle in which the counter equals TLIM, giving a period of TLIM+1 cycles.
REQ-023 The debounce shift register SHALL shift timer_button in only on cycles where evt_tick=1; all other cycles hold it.
REQ-024 When the shift register is all ones and armed=1, timer_status SHALL toggle and armed SHALL clear, both on that same tick cycle.
REQ-025 When the shift register is all zeros, armed SHALL set; mixed contents SHALL leave armed and timer_status unchanged.
REQ-026 For EVT_MODE=0, vm_evnt SHALL equal evt_tick AND timer_status (combinational, one cycle wide).
REQ-027 For EVT_MODE=1, vm_evnt SHALL be registered: it sets on the edge after evt_tick=1 with timer_status=1, and clears on the edge after evnt_ack=1.
REQ-028 For EVT_MODE=1, a set condition and evnt_ack in the same cycle SHALL leave vm_evnt=1 (set dominates).
REQ-029 For EVT_MODE=1, if vm_evnt=1 and evnt_ack=0 when a set condition occurs, evt_miss SHALL set and stay set until dclo.
REQ-030 For EVT_MODE=1, timer_status=0 SHALL clear vm_evnt on the next edge.
REQ-031 For EVT_MODE=0, evt_miss SHALL be constant 0.

Reset
REQ-032 While dclo=1, the following SHALL be forced on each edge: both counters 0, cpu_clk_enable 0, evt_tick 0, shift register 0, armed 1, timer_status 0, registered vm_evnt 0, evt_miss 0.
REQ-033 dclo asserted mid-count or mid-debounce SHALL abandon that progress; the first evt_tick SHALL occur TLIM+1 cycles after the dclo release edge.
REQ-034 With cpuslow=1, the first cpu_clk_enable SHALL occur SLOW_DIV cycles after dclo release.

Verification
REQ-035 CLKREF=1000, EVT_HZ=50, hold dclo 3 cycles -> evt_tick pulses every 20 cycles, first pulse 20 cycles after release; vm_evnt stays 0 because timer_status=0.
REQ-036 SLOW_DIV=22, cpuslow=1 -> cpu_clk_enable high 1 of every 22 cycles; switch cpuslow=0 -> enable high continuously from the next cycle.
REQ-037 DEB_LEN=2, hold timer_button=1 for 3 ticks -> timer_status goes to 1 exactly at the 2nd tick and no further toggle occurs; release for 2 ticks then press for 2 ticks -> timer_status returns to 0.
REQ-038 Button glitch of 1 cycle between ticks, or alternating samples at ticks -> timer_status unchanged.
REQ-039 EVT_MODE=1, timer_status=1, no ack across two ticks -> vm_evnt stays 1 and evt_miss=1 after the 2nd tick; ack coincident with a tick -> vm_evnt stays 1 and evt_miss is unchanged.
REQ-040 dclo pulsed while vm_evnt=1, evt_miss=1 and timer_status=1 -> all three read 0 the cycle after the dclo edge.
